imgproc_ctrl: RTL and testbench

Sequencer between the 128x128 source image memory port and the per-pixel imgproc datapath. It fetches 24-bit RGB pixels in raster order and tolerates orig_ready gaps, including the all-zero pixel case, which never raises orig_ready. It feeds each pixel to a fixed-latency datapath and schedules the 8-bit results onto the write-back port with matching addresses. It asserts finish once the last result has been written.

---
 rtl/imgproc_pkg.sv | 14 +
 rtl/imgproc_tag_pipe.sv | 39 +++
 rtl/imgproc_ctrl.sv | 145 ++++++++++++++
 tb/tb_imgproc_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imgproc_pkg.sv
// Shared definitions for the imgproc frame sequencer.
package imgproc_pkg;
    localparam int ADDR_W = 14;
    localparam int N_PIX  = 16384;
    localparam int PIX_W  = 24;
    localparam int RES_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/imgproc_tag_pipe.sv
// Valid/address delay line that follows each pixel through the datapath.
// The tap is DEPTH cycles behind i_valid; o_empty is high when no stage holds
// a pixel.
module imgproc_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [AW-1:0] i_addr,
    output logic          o_valid,
    output logic [AW-1:0] o_addr,
    output logic          o_empty
);
    import imgproc_pkg::*;

    logic [DEPTH-1:0] r_valid;
    logic [AW-1:0]    r_addr [DEPTH];

    // Shift the tag of every in-flight pixel one stage per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) r_addr[i] <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_addr[0]  <= i_addr;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_addr[i]  <= r_addr[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_addr  = r_addr[DEPTH-1];
    assign o_empty = (r_valid == '0);
endmodule

// File: rtl/imgproc_ctrl.sv
// Frame sequencer: fetches pixels in raster order (forcing a zero pixel after
// MISS_LIMIT silent cycles), feeds the datapath and writes each result back to
// the address it was fetched from. finish rises once the last write is out.
module imgproc_ctrl #(
    parameter int ADDR_W     = imgproc_pkg::ADDR_W,
    parameter int N_PIX      = imgproc_pkg::N_PIX,
    parameter int DP_LAT     = 2,
    parameter int MISS_LIMIT = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [imgproc_pkg::PIX_W-1:0]    orig_data,
    input  logic                             orig_ready,
    output logic                             request,
    output logic [ADDR_W-1:0]                orig_addr,
    output logic                             dp_valid,
    output logic [imgproc_pkg::PIX_W-1:0]    dp_pixel,
    input  logic [imgproc_pkg::RES_W-1:0]    dp_result,
    output logic                             imgproc_ready,
    output logic [ADDR_W-1:0]                imgproc_addr,
    output logic [imgproc_pkg::RES_W-1:0]    imgproc_data,
    output logic                             finish,
    output imgproc_pkg::state_t              o_dbg_state
);
    import imgproc_pkg::*;

    localparam int MW = $clog2(MISS_LIMIT) + 1;

    state_t             r_state;
    logic               r_request;
    logic [ADDR_W-1:0]  r_addr;
    logic [MW-1:0]      r_miss;
    logic               r_last;
    logic               r_dp_valid;
    logic [PIX_W-1:0]   r_dp_pixel;
    logic [ADDR_W-1:0]  r_dp_addr;
    logic               r_finish;
    logic               r_wb_valid;
    logic [ADDR_W-1:0]  r_wb_addr;
    logic [RES_W-1:0]   r_wb_data;

    logic               w_accept;
    logic               w_forced;
    logic               w_tap_valid;
    logic [ADDR_W-1:0]  w_tap_addr;
    logic               w_tag_empty;

    // A pixel is taken when the memory answers or the miss budget runs out.
    assign w_forced = (r_miss == MW'(MISS_LIMIT - 1)) && !orig_ready;
    assign w_accept = (r_state == FETCH) && (orig_ready || w_forced);

    // Sequencer FSM with registered request, address, datapath strobe and finish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_request  <= 1'b0;
            r_addr     <= '0;
            r_miss     <= '0;
            r_last     <= 1'b0;
            r_dp_valid <= 1'b0;
            r_dp_pixel <= '0;
            r_dp_addr  <= '0;
            r_finish   <= 1'b0;
        end else begin
            r_dp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_state   <= FETCH;
                    r_request <= 1'b1;
                    r_addr    <= '0;
                    r_miss    <= '0;
                    r_last    <= (N_PIX == 1);
                end
                FETCH: begin
                    if (w_accept) begin
                        r_dp_valid <= 1'b1;
                        r_dp_pixel <= orig_ready ? orig_data : '0;
                        r_dp_addr  <= r_addr;
                        r_miss     <= '0;
                        if (r_last) begin
                            // Address stays on the last pixel; no wrap to 0.
                            r_request <= 1'b0;
                            r_state   <= DRAIN;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                            r_last <= (r_addr == ADDR_W'(N_PIX - 2));
                        end
                    end else if (r_miss != MW'(MISS_LIMIT - 1)) begin
                        r_miss <= r_miss + 1'b1;
                    end
                end
                DRAIN: begin
                    // The output register takes its last load on this edge at
                    // the latest, so finish lines up with the cycle after it.
                    if (!r_dp_valid && w_tag_empty) begin
                        r_state  <= DONE;
                        r_finish <= 1'b1;
                    end
                end
                DONE: begin
                    r_finish <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    imgproc_tag_pipe #(
        .DEPTH (DP_LAT),
        .AW    (ADDR_W)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_dp_valid),
        .i_addr  (r_dp_addr),
        .o_valid (w_tap_valid),
        .o_addr  (w_tap_addr),
        .o_empty (w_tag_empty)
    );

    // Capture the datapath result in the cycle its tag reaches the tap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= w_tap_valid;
            if (w_tap_valid) begin
                r_wb_addr <= w_tap_addr;
                r_wb_data <= dp_result;
            end
        end
    end

    assign request       = r_request;
    assign orig_addr     = r_addr;
    assign dp_valid      = r_dp_valid;
    assign dp_pixel      = r_dp_pixel;
    assign imgproc_ready = r_wb_valid;
    assign imgproc_addr  = r_wb_addr;
    assign imgproc_data  = r_wb_data;
    assign finish        = r_finish;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_imgproc_ctrl.sv
// Bench for imgproc_ctrl: a 16-pixel instance driven from a scenario table and
// a default 128x128 instance run once with random data and zero pixels.
module tb_imgproc_ctrl;
  import imgproc_pkg::*;

  localparam int SN  = 16;
  localparam int FN  = 16384;
  localparam int LAT = 2;
  localparam int ML  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- small instance ----------------
  logic rst = 1'b1;
  logic [23:0] orig_data;
  logic orig_ready;
  logic request, dp_valid, imgproc_ready, finish;
  logic [13:0] orig_addr, imgproc_addr;
  logic [23:0] dp_pixel;
  logic [7:0] dp_result, imgproc_data;
  state_t dbg_state;

  imgproc_ctrl #(.ADDR_W(14), .N_PIX(SN), .DP_LAT(LAT), .MISS_LIMIT(ML)) u_dut (
    .clk(clk), .rst(rst), .orig_data(orig_data), .orig_ready(orig_ready),
    .request(request), .orig_addr(orig_addr), .dp_valid(dp_valid),
    .dp_pixel(dp_pixel), .dp_result(dp_result), .imgproc_ready(imgproc_ready),
    .imgproc_addr(imgproc_addr), .imgproc_data(imgproc_data), .finish(finish),
    .o_dbg_state(dbg_state)
  );

  // identity datapath, two cycles deep
  logic [7:0] s_p1, s_p2;
  always @(posedge clk) begin
    s_p1 <= dp_pixel[7:0];
    s_p2 <= s_p1;
  end
  assign dp_result = s_p2;

  // ---------------- full-frame instance ----------------
  logic f_rst = 1'b1;
  logic [23:0] f_orig_data;
  logic f_orig_ready;
  logic f_request, f_dp_valid, f_imgproc_ready, f_finish;
  logic [13:0] f_orig_addr, f_imgproc_addr;
  logic [23:0] f_dp_pixel;
  logic [7:0] f_dp_result, f_imgproc_data;
  state_t f_dbg_state;

  imgproc_ctrl u_full (
    .clk(clk), .rst(f_rst), .orig_data(f_orig_data), .orig_ready(f_orig_ready),
    .request(f_request), .orig_addr(f_orig_addr), .dp_valid(f_dp_valid),
    .dp_pixel(f_dp_pixel), .dp_result(f_dp_result), .imgproc_ready(f_imgproc_ready),
    .imgproc_addr(f_imgproc_addr), .imgproc_data(f_imgproc_data), .finish(f_finish),
    .o_dbg_state(f_dbg_state)
  );

  function automatic logic [7:0] mix(input logic [23:0] p);
    return p[23:16] ^ p[15:8] ^ p[7:0];
  endfunction

  logic [7:0] f_p1, f_p2;
  always @(posedge clk) begin
    f_p1 <= mix(f_dp_pixel);
    f_p2 <= f_p1;
  end
  assign f_dp_result = f_p2;

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    int zero_idx;    // pixel stored as zero, -1 for none
    bit gaps;        // random 0..3 cycle ready gaps on nonzero pixels
    int rst_at;      // pulse rst when this address is fetched, -1 for none
    int fin_base;    // finish cycle with the random gaps removed
  } vec_t;

  vec_t vecs[6];

  logic [23:0] mem [SN];
  int gap [SN];
  int hold [SN];
  logic [23:0] exp_dp_q[$];
  logic [21:0] exp_q[$];   // {addr, data}

  task automatic run_frame(input vec_t v, output bit aborted);
    int exp_fin, cyc, last_a, wcnt;
    bit done;
    logic [21:0] e;
    aborted = 1'b0;
    exp_fin = v.fin_base;
    exp_dp_q.delete();
    exp_q.delete();
    for (int a = 0; a < SN; a++) begin
      mem[a] = 24'($urandom_range(1, 24'hFFFFFF));
      if (a == v.zero_idx) mem[a] = 24'h0;
      gap[a] = (v.gaps && a != v.zero_idx) ? $urandom_range(0, 3) : 0;
      exp_fin += gap[a];
      hold[a] = 0;
      exp_dp_q.push_back(mem[a]);
      exp_q.push_back({14'(a), mem[a][7:0]});
    end
    rst = 1'b1;
    orig_ready = 1'b0;
    orig_data = 24'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    last_a = -1;
    wcnt = 0;
    done = 1'b0;
    check("reset_outputs", {request, dp_valid, imgproc_ready, finish, orig_addr}, 0);
    check("reset_state", dbg_state, IDLE);
    while (!done && cyc < 300) begin
      // memory: drive the answer for the address currently on the port
      if (!request) begin
        orig_ready = 1'b0;
        orig_data = 24'($urandom);
      end else begin
        if (int'(orig_addr) != last_a) begin
          last_a = int'(orig_addr);
          wcnt = 0;
        end
        orig_ready = (mem[orig_addr[3:0]] != 24'h0) && (wcnt >= gap[orig_addr[3:0]]);
        orig_data = orig_ready ? mem[orig_addr[3:0]] : 24'($urandom);
        wcnt++;
      end
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("first_request", {request, orig_addr}, {1'b1, 14'd0});
      if (request && orig_addr < SN) hold[orig_addr[3:0]]++;
      if (request && orig_addr >= SN) check("addr_range", orig_addr, SN - 1);
      if (dp_valid) begin
        if (exp_dp_q.size() == 0) check("dp_extra", 1, 0);
        else check("dp_pixel", dp_pixel, exp_dp_q.pop_front());
      end
      if (imgproc_ready) begin
        if (exp_q.size() == 0) check("wb_extra", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("wb_addr_data", {imgproc_addr, imgproc_data}, e);
        end
      end
      if (v.rst_at >= 0 && request && int'(orig_addr) == v.rst_at) begin
        rst = 1'b1;
        #1;
        check("async_reset_clear",
              {request, dp_valid, imgproc_ready, finish, orig_addr, imgproc_addr, dp_pixel}, 0);
        aborted = 1'b1;
        return;
      end
      if (finish) begin
        done = 1'b1;
        check("finish_cycle", cyc, exp_fin);
      end
    end
    if (!done) check("finish_timeout", 0, 1);
    check("end_request_addr", {request, orig_addr}, {1'b0, 14'(SN - 1)});
    check("all_written", exp_q.size(), 0);
    for (int a = 0; a < SN; a++)
      check($sformatf("hold_addr%0d", a), hold[a], (a == v.zero_idx) ? ML : gap[a] + 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("done_hold", {finish, request, dp_valid, imgproc_ready}, 4'b1000);
    end
  endtask

  task automatic run_full();
    logic [23:0] fmem [FN];
    int nz, exp_fin, cyc, wi, last_wb;
    bit done;
    nz = 0;
    for (int a = 0; a < FN; a++) begin
      fmem[a] = ($urandom_range(0, 63) == 0) ? 24'h0 : 24'($urandom_range(1, 24'hFFFFFF));
      if (fmem[a] == 24'h0) nz++;
    end
    fmem[FN-1] = 24'h0;   // last pixel is a forced zero
    nz = 0;
    for (int a = 0; a < FN; a++) if (fmem[a] == 24'h0) nz++;
    exp_fin = FN + LAT + 3 + nz * (ML - 1);
    f_rst = 1'b1;
    f_orig_ready = 1'b0;
    f_orig_data = 24'h0;
    @(negedge clk);
    @(negedge clk);
    f_rst = 1'b0;
    cyc = 0;
    wi = 0;
    last_wb = -1;
    done = 1'b0;
    while (!done && cyc < 40000) begin
      f_orig_ready = f_request && (fmem[f_orig_addr] != 24'h0);
      f_orig_data = f_orig_ready ? fmem[f_orig_addr] : 24'($urandom);
      @(negedge clk);
      cyc++;
      if (f_imgproc_ready) begin
        if (wi >= FN) check("full_wb_extra", 1, 0);
        else check("full_wb", {f_imgproc_addr, f_imgproc_data}, {14'(wi), mix(fmem[wi])});
        last_wb = int'(f_imgproc_addr);
        wi++;
      end
      if (f_finish) begin
        done = 1'b1;
        check("full_finish_cycle", cyc, exp_fin);
      end
    end
    if (!done) check("full_finish_timeout", 0, 1);
    check("full_write_count", wi, FN);
    check("full_last_wb_addr", last_wb, FN - 1);
    check("full_end_request_addr", {f_request, f_orig_addr}, {1'b0, 14'(FN - 1)});
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check("full_done_hold", {f_finish, f_request, f_dp_valid, f_imgproc_ready, f_orig_addr},
            {4'b1000, 14'(FN - 1)});
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ab;
    orig_ready = 1'b0;
    orig_data = 24'h0;
    f_orig_ready = 1'b0;
    f_orig_data = 24'h0;
    vecs[0] = '{zero_idx: -1, gaps: 1'b0, rst_at: -1, fin_base: SN + LAT + 3};
    vecs[1] = '{zero_idx:  5, gaps: 1'b0, rst_at: -1, fin_base: SN + LAT + 3 + ML - 1};
    vecs[2] = '{zero_idx: -1, gaps: 1'b1, rst_at: -1, fin_base: SN + LAT + 3};
    vecs[3] = '{zero_idx: -1, gaps: 1'b0, rst_at:  9, fin_base: SN + LAT + 3};
    vecs[4] = '{zero_idx:  0, gaps: 1'b1, rst_at: -1, fin_base: SN + LAT + 3 + ML - 1};
    vecs[5] = '{zero_idx: SN - 1, gaps: 1'b0, rst_at: -1, fin_base: SN + LAT + 3 + ML - 1};
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i], ab);
      if (ab) begin
        // restart from address 0 after the mid-frame reset
        vecs[i].rst_at = -1;
        run_frame(vecs[i], ab);
      end
    end
    // second gap run with fresh random gaps
    run_frame(vecs[2], ab);
    run_full();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
